// File: rtl/ab_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ab_input_conditioner_pkg
// Purpose  : Shared definitions for the a/b input conditioner.
//            Provides the default debounce interval and the bundle type
//            that carries one channel's conditioned outputs.
// Revision : 1.0 - initial release
// ============================================================================
package ab_input_conditioner_pkg;

    // 10 ms at 100 MHz
    localparam int C_DEFAULT_STABLE_CYCLES = 1000000;

    // Conditioned outputs of a single channel
    typedef struct packed {
        logic clean;
        logic rise;
        logic fall;
    } chan_out_t;

endpackage : ab_input_conditioner_pkg
`default_nettype wire

// File: rtl/ab_input_conditioner_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One raw asynchronous input -> two-flop synchronizer -> debounce
//            counter -> clean level with registered rise/fall pulses.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            raw   - raw pad input, asynchronous to clk
//            clean - debounced level
//            rise  - one-cycle pulse coincident with clean going 0->1
//            fall  - one-cycle pulse coincident with clean going 1->0
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import ab_input_conditioner_pkg::*;
#(
    parameter int STABLE_CYCLES = C_DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_rise;
    logic             r_fall;

    logic             w_differs;
    logic             w_cnt_last;

    // Plain two-flop synchronizer: nothing may sit between r_s1 and r_s2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
        end
    end

    assign w_differs  = r_s2 ^ r_clean;
    assign w_cnt_last = (r_cnt == C_CNT_LAST);

    // The counter tracks how many consecutive samples have disagreed with the
    // clean level. Any agreeing sample clears it, so a glitch earns no credit.
    // It saturates by construction: reaching C_CNT_LAST always updates clean
    // and clears the count on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (!w_cnt_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt   <= '0;
                r_clean <= r_s2;
                r_rise  <= r_s2;
                r_fall  <= ~r_s2;
            end
        end
    end

    assign clean = r_clean;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/ab_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : ab_input_conditioner
// Purpose  : Conditions the raw a/b board inputs for the two-input logic
//            stage: synchronize, debounce, and flag every clean-level edge.
// Ports    : clk, rst_n        - clock / asynchronous active-low reset
//            a_raw, b_raw      - raw asynchronous pad inputs
//            a, b              - debounced levels
//            a_rise, a_fall    - one-cycle edge pulses for a
//            b_rise, b_fall    - one-cycle edge pulses for b
//            ab_change         - OR of all four edge pulses
// Revision : 1.0 - initial release
// ============================================================================
module ab_input_conditioner
    import ab_input_conditioner_pkg::*;
#(
    parameter int STABLE_CYCLES = C_DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic ab_change
);

    chan_out_t w_a_out;
    chan_out_t w_b_out;

    debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (a_raw),
        .clean (w_a_out.clean),
        .rise  (w_a_out.rise),
        .fall  (w_a_out.fall)
    );

    debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (b_raw),
        .clean (w_b_out.clean),
        .rise  (w_b_out.rise),
        .fall  (w_b_out.fall)
    );

    assign a      = w_a_out.clean;
    assign b      = w_b_out.clean;
    assign a_rise = w_a_out.rise;
    assign a_fall = w_a_out.fall;
    assign b_rise = w_b_out.rise;
    assign b_fall = w_b_out.fall;

    // Simultaneous a/b updates merge into a single strobe cycle.
    assign ab_change = w_a_out.rise | w_a_out.fall | w_b_out.rise | w_b_out.fall;

endmodule : ab_input_conditioner
`default_nettype wire

// File: tb/tb_ab_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ab_input_conditioner
// Purpose  : Randomized plus directed stimulus for ab_input_conditioner with
//            a window-based reference model feeding an expected-value queue
//            and an independent monitor that checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ab_input_conditioner;

    localparam int C_STABLE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic a, b, a_rise, a_fall, b_rise, b_fall, ab_change;

    ab_input_conditioner #(
        .STABLE_CYCLES (C_STABLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_raw     (a_raw),
        .b_raw     (b_raw),
        .a         (a),
        .b         (b),
        .a_rise    (a_rise),
        .a_fall    (a_fall),
        .b_rise    (b_rise),
        .b_fall    (b_fall),
        .ab_change (ab_change)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ea;
        logic eb;
        logic ea_rise;
        logic ea_fall;
        logic eb_rise;
        logic eb_fall;
        logic echg;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cycle  = 0;
    int   pulses = 0;
    bit   done   = 1'b0;

    // ------------------------------------------------------------------
    // Reference model. The debouncer acts on the raw level seen two edges
    // earlier; the clean level flips once the last C_STABLE such samples
    // (taken since reset and since the previous flip) all disagree with it.
    // ------------------------------------------------------------------
    logic m_clean [2];
    logic m_hist  [2][2];
    int   m_nhist [2];
    logic m_win   [2][C_STABLE];
    int   m_nwin  [2];

    always @(posedge clk) begin : model
        exp_t e;
        logic raws [2];
        logic rs   [2];
        logic fs   [2];
        logic s;
        bit   all_diff;
        raws[0] = a_raw;
        raws[1] = b_raw;
        cycle++;
        for (int ch = 0; ch < 2; ch++) begin
            rs[ch] = 1'b0;
            fs[ch] = 1'b0;
            if (!rst_n) begin
                m_clean[ch] = 1'b0;
                m_nhist[ch] = 0;
                m_nwin[ch]  = 0;
            end else begin
                s = (m_nhist[ch] == 2) ? m_hist[ch][0] : 1'b0;
                if (m_nhist[ch] == 2) begin
                    m_hist[ch][0] = m_hist[ch][1];
                    m_hist[ch][1] = raws[ch];
                end else begin
                    m_hist[ch][m_nhist[ch]] = raws[ch];
                    m_nhist[ch]++;
                end
                if (m_nwin[ch] == C_STABLE) begin
                    for (int k = 0; k < C_STABLE - 1; k++) m_win[ch][k] = m_win[ch][k+1];
                    m_win[ch][C_STABLE-1] = s;
                end else begin
                    m_win[ch][m_nwin[ch]] = s;
                    m_nwin[ch]++;
                end
                all_diff = (m_nwin[ch] == C_STABLE);
                for (int k = 0; k < C_STABLE; k++)
                    if (k < m_nwin[ch] && m_win[ch][k] == m_clean[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    rs[ch]      = s;
                    fs[ch]      = ~s;
                    m_clean[ch] = s;
                    m_nwin[ch]  = 0;
                end
            end
        end
        e.ea      = m_clean[0];
        e.eb      = m_clean[1];
        e.ea_rise = rs[0];
        e.ea_fall = fs[0];
        e.eb_rise = rs[1];
        e.eb_fall = fs[1];
        e.echg    = rs[0] | fs[0] | rs[1] | fs[1];
        exp_q.push_back(e);
    end

    // ------------------------------------------------------------------
    // Monitor: the outputs are live every cycle, so one entry is consumed
    // at every falling edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        if (!done) begin
            got = {a, b, a_rise, a_fall, b_rise, b_fall, ab_change};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty cyc=%0d got=%b required=entry", cycle, got);
            end else begin
                e = exp_q.pop_front();
                if (e.echg) pulses++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got{a,b,ar,af,br,bf,chg}=%b required=%b",
                             cycle, got, e);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: raw inputs change 2 ns after a rising edge; reset changes
    // 1 ns after a falling edge so the monitor never straddles it.
    // ------------------------------------------------------------------
    task automatic hold(input int n, input logic va, input logic vb);
        a_raw = va;
        b_raw = vb;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (n) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin : driver
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;
        // idle, then a rises
        hold(20, 1'b0, 1'b0);
        hold(12, 1'b1, 1'b0);
        // short drop on a is rejected
        hold(2, 1'b0, 1'b0);
        hold(10, 1'b1, 1'b0);
        // both fall, then both rise together
        hold(12, 1'b0, 1'b0);
        hold(12, 1'b1, 1'b1);
        // b falls alone
        hold(12, 1'b1, 1'b0);
        // a drops, then rises and is reset mid-count with a held high
        hold(12, 1'b0, 1'b0);
        hold(2, 1'b1, 1'b0);
        pulse_reset(2);
        hold(12, 1'b1, 1'b0);
        // randomized levels and hold times, occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 60) == 0) pulse_reset($urandom_range(1, 3));
            hold($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        hold(12, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 done = 1'b1;
        tests++;
        if (pulses == 0) begin
            fails++;
            $display("FAIL pulse_activity got=%0d required=nonzero", pulses);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ab_input_conditioner
`default_nettype wire

// File: doc/ab_input_conditioner.md
Name: ab_input_conditioner

Overview:
- Front-end stage that directly feeds the two-input logic stage (inputs a, b → output f).
- Takes raw, asynchronous board inputs (slide switches or push buttons) for a and b.
- Per channel: synchronizes to clk, debounces, and presents clean levels plus single-cycle edge pulses.
- The downstream gate logic therefore sees only stable, glitch-free a/b.

Parameters:
- STABLE_CYCLES, 1000000, consecutive cycles a synchronized input must differ from the current clean level before the clean level updates (10 ms at 100 MHz). Legal range ≥ 2.
- CNT_W, $clog2(STABLE_CYCLES), debounce counter width. Derived; not overridden by users.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- a_raw  input  1  raw pad input for operand a; asynchronous to clk.
- b_raw  input  1  raw pad input for operand b; asynchronous to clk.
- a  output  1  debounced level of a; feeds the downstream stage's input a.
- b  output  1  debounced level of b; feeds the downstream stage's input b.
- a_rise  output  1  one-cycle pulse when a goes 0→1.
- a_fall  output  1  one-cycle pulse when a goes 1→0.
- b_rise  output  1  one-cycle pulse when b goes 0→1.
- b_fall  output  1  one-cycle pulse when b goes 1→0.
- ab_change  output  1  OR of all four edge pulses; strobe telling downstream that f may have changed.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low via rst_n.
- Reset: while rst_n=0, all of the following are 0: sync flops, counters, a, b, a_rise, a_fall, b_rise, b_fall, ab_change.
- Synchronizer: two-flop chain per channel (raw→s1→s2). No logic between the flops.
- Per-channel debounce (identical for a and b, fully independent):
  - s2 == clean: cnt ← 0; pulses ← 0.
  - s2 != clean and cnt < STABLE_CYCLES-1: cnt ← cnt+1.
  - s2 != clean and cnt == STABLE_CYCLES-1: clean ← s2; cnt ← 0; assert rise (if s2=1) or fall (if s2=0) for exactly this one registered cycle.
- Glitch rejection: any return of s2 to the clean level before the count completes clears cnt. The next differing sample restarts the count from 0; no partial credit is kept.
- Latency:
  - Count edges starting at 1 for the first rising edge that samples the new raw level.
  - The clean output and its edge pulse both become visible after edge STABLE_CYCLES+2.
  - The pulse deasserts after the following edge.
- Pulses are registered and coincide with the clean-level change, never before it.
- Simultaneous events:
  - a and b may update on the same cycle; each asserts its own pulse.
  - ab_change is a single one-cycle pulse in that case.
- Reset mid-count: the count is discarded. After release the count starts from 0.
- Reset with input held: raw held at 1 through reset release is treated as a 0→1 change. The rise pulse fires after the full latency, measured from the first post-reset sampling edge.
- Counter never wraps: it is bounded at STABLE_CYCLES-1 by the rules above.
- All outputs are driven directly from flops (ab_change may be the OR of four flops).

Decomposition:
- No shared package needed; STABLE_CYCLES/CNT_W are module parameters.
- One sub-module is natural: debounce_channel (clk, rst_n, raw, clean, rise, fall) with the same parameters.
  - Contains the synchronizer, counter and update logic.
  - Instantiated twice; top level adds the ab_change OR.

Test Plan (STABLE_CYCLES=4 → latency 6 edges):
- Reset, then a_raw held 0 for 20 cycles → a, a_rise, a_fall, ab_change stay 0 throughout.
- a_raw 0→1 sampled at edge 1 and held → a=1 and a_rise=1 after edge 6; a_rise=0 after edge 7; ab_change mirrors a_rise; b and b pulses unaffected.
- a=1 stable, a_raw drops to 0 for 2 cycles then returns to 1 → a stays 1; no a_fall pulse; cnt returns to 0.
- a_raw and b_raw both 0→1 on the same edge → a and b rise after edge 6; a_rise and b_rise both pulse; ab_change is one single-cycle pulse.
- a_raw 0→1; assert rst_n=0 at edge 3 for 2 cycles, a_raw still 1 → a=0 during reset; after release a rises 6 edges after the first post-reset sampling edge, with a_rise pulse.
- b=1 stable, b_raw 1→0 held → b=0 and b_fall pulse after edge 6; b_rise never asserts.
